cola_escritura_reg: RTL
=======================

Name: cola_escritura_reg

Overview:
Write-side companion to the 32x32 register bank. It accepts register write requests from the execute/writeback stage through a valid/ready handshake and buffers them in a small in-order queue. It drains one entry per cycle onto the bank's write port (RWEN/DirWrite/DatoNuevo). It also provides combinational read-bypass of pending writes, so the bank's two read ports never return stale data.

Parameters:
DEPTH, 4, number of queue entries (power of two, 2..16)
AW, 5, register address width (32 registers)
DW, 32, register data width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  producer presents a write request
in_ready  output  1  queue can accept a request this cycle
in_dir  input  AW  destination register of request
in_dato  input  DW  data of request
drain_en  input  1  bank side permits a write this cycle
RWEN  output  1  write enable to register bank (registered)
DirWrite  output  AW  write address to register bank (registered)
DatoNuevo  output  DW  write data to register bank (registered)
Dir1  input  AW  read address 1 (same value driven to the bank)
Dir2  input  AW  read address 2 (same value driven to the bank)
Hit1  output  1  a pending queue entry targets Dir1
Fwd1  output  DW  youngest pending data for Dir1
Hit2  output  1  a pending queue entry targets Dir2
Fwd2  output  DW  youngest pending data for Dir2
count  output  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset, sampled on clk edge with rst=1: count=0, read/write pointers=0, RWEN=0, DirWrite=0, DatoNuevo=0, all entry valid bits cleared. A reset mid-drain discards all pending entries and any in-flight write; RWEN is 0 on the cycle after the reset edge.
- in_ready = (count < DEPTH). It is combinational from count only, with no dependence on drain_en.
- Push: occurs on an edge with in_valid && in_ready. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
  - Requests with in_dir==0 are accepted (handshake completes) but not stored: no pointer or count change.
- Pop: occurs on an edge with drain_en && count>0. On the same edge, RWEN<=1, DirWrite<=head dir, DatoNuevo<=head data, and rd_ptr increments modulo DEPTH.
- On an edge with no pop: RWEN<=0; DirWrite and DatoNuevo hold their previous values.
- Simultaneous push and pop: count unchanged. Push of a reg-0 request with pop: count decrements.
- Pop never sees an entry pushed on the same edge. Minimum latency from the accepting edge N to RWEN=1 is edge N+1.
- Ordering is strictly FIFO. Two writes to the same register reach the bank in acceptance order.
- Bypass is combinational and covers only entries still in the queue. The entry currently presented on RWEN is already visible through the bank, so it is excluded.
  - Hit1 = 1 if any valid entry has dir==Dir1 and Dir1!=0. Fwd1 is the data of the youngest such entry (closest to wr_ptr); Fwd1=0 when Hit1=0.
  - Hit2/Fwd2 are identical in form for Dir2.
  - An entry popped on the current edge stops contributing from the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits. Full versus empty is distinguished by count, not pointer equality.
- count never exceeds DEPTH and never underflows. A pop with count==0 is a no-op.
- The drain rate is one write per cycle. The bank's write port is never driven for more than one cycle per entry.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> RWEN=0, DirWrite=0, DatoNuevo=0, count=0, in_ready=1, Hit1=Hit2=0.
- Single write, drain_en=1: push (dir=5, dato=32'd99) at edge N -> edge N+1 RWEN=1, DirWrite=5, DatoNuevo=99; edge N+2 RWEN=0, count=0.
- Fill and backpressure, drain_en=0: push dirs 6,7,8,9 -> count=4, in_ready=0; a 5th request is held. Raise drain_en -> writes 6,7,8,9 appear on four consecutive cycles; in_ready=1 after the first pop edge.
- Bypass youngest: drain_en=0, push (12, 1) then (12, 2), Dir1=12, Dir2=13 -> Hit1=1, Fwd1=2, Hit2=0, Fwd2=0. After both drain -> Hit1=0.
- Register zero: push (0, 32'hDEAD) -> handshake completes, count stays 0, RWEN never asserts; Dir1=0 -> Hit1=0.
- Simultaneous push/pop at count=2 plus reset mid-drain: count stays 2 across the edge. Assert rst during drain -> next cycle RWEN=0, count=0, Hit1=0.

Source files
------------

// File: rtl/cola_escritura_reg.sv
// cola_escritura_reg
// In-order write queue in front of the 32x32 register bank. Requests are
// accepted through a valid/ready handshake. They are drained one per cycle
// onto the bank write port (RWEN/DirWrite/DatoNuevo). Pending entries are
// forwarded combinationally to both read ports so reads never see stale data.
// Writes to register 0 complete the handshake but are dropped, because that
// register is hard-wired in the bank.

module cola_escritura_reg #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_dir,
    input  logic [DW-1:0]            in_dato,
    input  logic                     drain_en,
    output logic                     RWEN,
    output logic [AW-1:0]            DirWrite,
    output logic [DW-1:0]            DatoNuevo,
    input  logic [AW-1:0]            Dir1,
    input  logic [AW-1:0]            Dir2,
    output logic                     Hit1,
    output logic [DW-1:0]            Fwd1,
    output logic                     Hit2,
    output logic [DW-1:0]            Fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Queue storage; vld_r marks entries not yet presented to the bank
    logic [AW-1:0]    mem_dir_r  [DEPTH];
    logic [DW-1:0]    mem_dato_r [DEPTH];
    logic [DEPTH-1:0] vld_r;

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic             rwen_r;
    logic [AW-1:0]    dir_write_r;
    logic [DW-1:0]    dato_nuevo_r;

    logic             push_s;
    logic             pop_s;
    logic [PW-1:0]    idx_s;
    logic             hit1_s;
    logic             hit2_s;
    logic [DW-1:0]    fwd1_s;
    logic [DW-1:0]    fwd2_s;

    // Full/empty come from the occupancy counter, never from pointer equality
    assign in_ready = (count_r < CW'(DEPTH));

    // A register-0 request is handshaken but produces no storage side effects.
    // A pop only looks at entries already present before this edge.
    assign push_s = in_valid && in_ready && (in_dir != {AW{1'b0}});
    assign pop_s  = drain_en && (count_r != {CW{1'b0}});

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage and valid bits (push and pop never hit the same slot)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_dir_r[i]  <= {AW{1'b0}};
                mem_dato_r[i] <= {DW{1'b0}};
            end
            vld_r <= {DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                mem_dir_r[wr_ptr_r]  <= in_dir;
                mem_dato_r[wr_ptr_r] <= in_dato;
                vld_r[wr_ptr_r]      <= 1'b1;
            end
            if (pop_s) begin
                vld_r[rd_ptr_r] <= 1'b0;
            end
        end
    end

    // Registered bank write port; address/data hold when nothing is drained
    always_ff @(posedge clk) begin
        if (rst) begin
            rwen_r       <= 1'b0;
            dir_write_r  <= {AW{1'b0}};
            dato_nuevo_r <= {DW{1'b0}};
        end else if (pop_s) begin
            rwen_r       <= 1'b1;
            dir_write_r  <= mem_dir_r[rd_ptr_r];
            dato_nuevo_r <= mem_dato_r[rd_ptr_r];
        end else begin
            rwen_r       <= 1'b0;
            dir_write_r  <= dir_write_r;
            dato_nuevo_r <= dato_nuevo_r;
        end
    end

    // Read bypass: scan oldest to youngest so the last match is the youngest
    always_comb begin
        hit1_s = 1'b0;
        fwd1_s = {DW{1'b0}};
        hit2_s = 1'b0;
        fwd2_s = {DW{1'b0}};
        idx_s  = rd_ptr_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = rd_ptr_r + PW'(i);
            if (vld_r[idx_s] && (mem_dir_r[idx_s] == Dir1) && (Dir1 != {AW{1'b0}})) begin
                hit1_s = 1'b1;
                fwd1_s = mem_dato_r[idx_s];
            end else begin
                hit1_s = hit1_s;
                fwd1_s = fwd1_s;
            end
            if (vld_r[idx_s] && (mem_dir_r[idx_s] == Dir2) && (Dir2 != {AW{1'b0}})) begin
                hit2_s = 1'b1;
                fwd2_s = mem_dato_r[idx_s];
            end else begin
                hit2_s = hit2_s;
                fwd2_s = fwd2_s;
            end
        end
    end

    assign RWEN      = rwen_r;
    assign DirWrite  = dir_write_r;
    assign DatoNuevo = dato_nuevo_r;
    assign Hit1      = hit1_s;
    assign Fwd1      = fwd1_s;
    assign Hit2      = hit2_s;
    assign Fwd2      = fwd2_s;
    assign count     = count_r;

endmodule
